// File: rtl/implode_read_sequencer.sv
// Read sequencer feeding implode from the scratchpad: two ascending passes,
// credit-limited prefetch FIFO that hides read latency, desync flag, abort flush.
module implode_read_sequencer #(
  parameter int NUM_ROUNDS = 'h020,
  parameter int RD_LATENCY = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         abort,
  input  logic         request_read,
  input  logic [31:0]  mem_address,
  output logic [127:0] data_out,
  output logic         data_valid,
  output logic         mem_rd_en,
  output logic [31:0]  mem_rd_addr,
  input  logic         mem_grant,
  input  logic [127:0] mem_rd_data,
  output logic         busy,
  output logic         done,
  output logic         addr_err
);

  localparam int W  = NUM_ROUNDS << 3;
  localparam int CW = $clog2(2 * W) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 2;
  localparam int FW = $clog2(RD_LATENCY + 1);

  localparam logic [CW-1:0] TOTAL    = CW'(2 * W);
  localparam logic [CW-1:0] TOTAL_M1 = CW'(2 * W - 1);
  localparam logic [31:0]   LAST     = 32'(W - 1);
  localparam logic [OW-1:0] DEPTH    = OW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FL_LAST  = FW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  state_t state, state_nxt;

  logic [31:0]           issue_addr;
  logic [31:0]           pop_addr;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         pop_cnt;
  logic [RD_LATENCY-1:0] vpipe;
  logic [FW-1:0]         flush_cnt;
  logic [127:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           fifo_cnt;
  logic [OW-1:0]         inflight;
  logic [OW-1:0]         occ;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  last_pop;
  logic                  start_go;
  logic                  abort_go;
  logic                  clear;

  // credits cover in-flight reads, so a push always has a slot
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + OW'(vpipe[i]);
  end

  assign occ      = OW'(fifo_cnt) + inflight;
  assign start_go = start && (state == IDLE);
  assign abort_go = abort
                 && ((state == RUN) || (state == DRAIN));
  assign clear    = abort_go || (state == FLUSH);

  assign mem_rd_en   = (state == RUN) && (occ < DEPTH)
                    && (issue_cnt < TOTAL);
  assign mem_rd_addr = issue_addr;
  assign issue       = mem_rd_en && mem_grant;
  assign push        = vpipe[RD_LATENCY-1] && !clear;

  assign data_valid = request_read && (fifo_cnt != '0)
                   && (state != FLUSH);
  assign pop        = data_valid;
  assign last_pop   = pop && (pop_cnt == TOTAL_M1);
  assign done       = (state == DRAIN) && last_pop && !abort;
  assign busy       = (state != IDLE);
  assign data_out   = (fifo_cnt != '0) ? fifo_mem[rd_ptr] : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (abort)
          state_nxt = FLUSH;
        else if (issue && (issue_cnt == TOTAL_M1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)         state_nxt = FLUSH;
        else if (last_pop) state_nxt = IDLE;
      end
      FLUSH: if (flush_cnt == FL_LAST) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      vpipe      <= '0;
      flush_cnt  <= '0;
      issue_addr <= '0;
      pop_addr   <= '0;
      issue_cnt  <= '0;
      pop_cnt    <= '0;
      addr_err   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      vpipe     <= (vpipe << 1) | RD_LATENCY'(issue);
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (start_go) begin
        issue_addr <= '0;
        pop_addr   <= '0;
        issue_cnt  <= '0;
        pop_cnt    <= '0;
        addr_err   <= 1'b0;
      end else begin
        if (issue) begin
          issue_addr <= (issue_addr == LAST) ? '0 : issue_addr + 1'b1;
          issue_cnt  <= issue_cnt + 1'b1;
        end
        if (pop) begin
          pop_addr <= (pop_addr == LAST) ? '0 : pop_addr + 1'b1;
          pop_cnt  <= pop_cnt + 1'b1;
          if (mem_address != pop_addr) addr_err <= 1'b1;
        end
      end
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rd_data;
  end

endmodule

// File: tb/tb_implode_read_sequencer.sv
// Directed bench for implode_read_sequencer (W=16, latency 3, depth 8)
// with a latency-3 memory model returning word = address.
module tb_implode_read_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         request_read = 1'b0;
  logic [31:0]  mem_address = '0;
  logic [127:0] data_out;
  logic         data_valid;
  logic         mem_rd_en;
  logic [31:0]  mem_rd_addr;
  logic         mem_grant = 1'b0;
  logic [127:0] mem_rd_data = '0;
  logic         busy;
  logic         done;
  logic         addr_err;

  implode_read_sequencer #(
    .NUM_ROUNDS(2),
    .RD_LATENCY(3),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .abort(abort),
    .request_read(request_read),
    .mem_address(mem_address),
    .data_out(data_out),
    .data_valid(data_valid),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_grant(mem_grant),
    .mem_rd_data(mem_rd_data),
    .busy(busy),
    .done(done),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc;
  int exp_idx, pops, issued, max_out, first_cyc, done_cyc;
  bit done_seen, do_start, acc;
  int req_lo_a, req_lo_b, gnt_lo_a, gnt_lo_b;
  int abort_at, rst_at, desync_idx;
  bit          p_v [3];
  logic [31:0] p_a [3];
  logic [31:0] acc_a;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic clear_sched();
    req_lo_a = -1; req_lo_b = -2;
    gnt_lo_a = -1; gnt_lo_b = -2;
    abort_at = -1; rst_at = -1;
    desync_idx = -1;
  endtask

  task automatic new_stream();
    cyc = -1; do_start = 1'b1;
    exp_idx = 0; pops = 0; issued = 0; max_out = 0;
    first_cyc = -1; done_cyc = -1; done_seen = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    p_v[2] = p_v[1]; p_a[2] = p_a[1];
    p_v[1] = p_v[0]; p_a[1] = p_a[0];
    p_v[0] = acc;    p_a[0] = acc_a;
    mem_rd_data = p_v[2] ? {96'd0, p_a[2]} : {4{32'hBAD0BAD0}};
    start = do_start && (cyc == 0);
    abort = (cyc == abort_at);
    rstn  = (cyc != rst_at);
    request_read = !(cyc >= req_lo_a && cyc <= req_lo_b);
    mem_grant    = !(cyc >= gnt_lo_a && cyc <= gnt_lo_b);
    mem_address  = (exp_idx == desync_idx) ?
                   32'((exp_idx % W) + 1) : 32'(exp_idx % W);
    #4;
    acc   = mem_rd_en && mem_grant;
    acc_a = mem_rd_addr;
    if (acc) issued++;
    if (data_valid) begin
      check("data", data_out, 128'(exp_idx % W));
      if (first_cyc < 0) first_cyc = cyc;
      exp_idx++;
      pops++;
    end
    if (issued - pops > max_out) max_out = issued - pops;
    if (done) begin
      done_seen = 1'b1;
      done_cyc = cyc;
    end
  endtask

  task automatic run_to_done(input int limit);
    for (int i = 0; i < limit && !done_seen; i++) tick();
    check("done_seen", 128'(done_seen), 128'(1));
  endtask

  initial begin
    clear_sched();
    do_start = 1'b0;
    acc = 1'b0; acc_a = '0;
    for (int i = 0; i < 3; i++) begin
      p_v[i] = 1'b0; p_a[i] = '0;
    end
    cyc = -100;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    check("rst_data_out", data_out, 128'd0);
    check("rst_data_valid", 128'(data_valid), 128'd0);
    check("rst_mem_rd_en", 128'(mem_rd_en), 128'd0);
    check("rst_mem_rd_addr", 128'(mem_rd_addr), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_addr_err", 128'(addr_err), 128'd0);

    // full stream
    clear_sched();
    new_stream();
    tick();
    tick();
    check("s1_busy_c1", 128'(busy), 128'd1);
    check("s1_en_c1", 128'(mem_rd_en), 128'd1);
    check("s1_addr_c1", 128'(mem_rd_addr), 128'd0);
    run_to_done(100);
    check("s1_pops", 128'(pops), 128'd32);
    check("s1_first", 128'(first_cyc), 128'd5);
    check("s1_done_cyc", 128'(done_cyc), 128'd36);
    check("s1_addr_err", 128'(addr_err), 128'd0);
    tick();
    check("s1_busy_after", 128'(busy), 128'd0);
    check("s1_done_after", 128'(done), 128'd0);

    // backpressure
    clear_sched();
    req_lo_a = 5; req_lo_b = 24;
    new_stream();
    repeat (10) tick();
    check("bp_en_c9", 128'(mem_rd_en), 128'd0);
    check("bp_issued_c9", 128'(issued), 128'd8);
    repeat (15) tick();
    check("bp_en_c24", 128'(mem_rd_en), 128'd0);
    check("bp_pops_c24", 128'(pops), 128'd0);
    run_to_done(200);
    check("bp_pops", 128'(pops), 128'd32);
    check("bp_max_out", 128'(max_out), 128'd8);
    check("bp_addr_err", 128'(addr_err), 128'd0);
    tick();

    // grant stall
    clear_sched();
    gnt_lo_a = 3; gnt_lo_b = 6;
    new_stream();
    repeat (4) tick();
    check("gs_en_c3", 128'(mem_rd_en), 128'd1);
    check("gs_addr_c3", 128'(mem_rd_addr), 128'd2);
    repeat (3) tick();
    check("gs_en_c6", 128'(mem_rd_en), 128'd1);
    check("gs_addr_c6", 128'(mem_rd_addr), 128'd2);
    tick();
    check("gs_acc_c7", 128'(acc), 128'd1);
    check("gs_addr_c7", 128'(acc_a), 128'd2);
    run_to_done(200);
    check("gs_pops", 128'(pops), 128'd32);
    check("gs_addr_err", 128'(addr_err), 128'd0);
    tick();

    // abort mid-run
    clear_sched();
    abort_at = 10;
    new_stream();
    repeat (11) tick();
    check("ab_busy_c10", 128'(busy), 128'd1);
    for (int c = 11; c <= 13; c++) begin
      tick();
      check("ab_valid_flush", 128'(data_valid), 128'd0);
      check("ab_en_flush", 128'(mem_rd_en), 128'd0);
      check("ab_busy_flush", 128'(busy), 128'd1);
    end
    tick();
    check("ab_busy_c14", 128'(busy), 128'd0);
    check("ab_valid_c14", 128'(data_valid), 128'd0);
    tick();
    clear_sched();
    new_stream();
    run_to_done(100);
    check("ab_re_pops", 128'(pops), 128'd32);
    check("ab_re_first", 128'(first_cyc), 128'd5);
    check("ab_re_done_cyc", 128'(done_cyc), 128'd36);
    tick();

    // desync
    clear_sched();
    desync_idx = 4;
    new_stream();
    repeat (10) tick();
    check("ds_pop_c9", 128'(data_valid), 128'd1);
    check("ds_err_c9", 128'(addr_err), 128'd0);
    tick();
    check("ds_err_c10", 128'(addr_err), 128'd1);
    run_to_done(100);
    check("ds_err_done", 128'(addr_err), 128'd1);
    tick();
    clear_sched();
    new_stream();
    tick();
    check("ds_err_c0", 128'(addr_err), 128'd1);
    tick();
    check("ds_err_cleared", 128'(addr_err), 128'd0);
    run_to_done(100);
    check("ds_err_clean", 128'(addr_err), 128'd0);
    tick();

    // reset mid-drain with four words buffered
    clear_sched();
    req_lo_a = 31; req_lo_b = 34;
    rst_at = 34;
    new_stream();
    repeat (34) tick();
    check("rd_busy_c33", 128'(busy), 128'd1);
    check("rd_pops_c33", 128'(pops), 128'd26);
    check("rd_en_c33", 128'(mem_rd_en), 128'd0);
    tick();
    tick();
    check("rd_data_out", data_out, 128'd0);
    check("rd_data_valid", 128'(data_valid), 128'd0);
    check("rd_mem_rd_en", 128'(mem_rd_en), 128'd0);
    check("rd_mem_rd_addr", 128'(mem_rd_addr), 128'd0);
    check("rd_busy", 128'(busy), 128'd0);
    check("rd_done", 128'(done), 128'd0);
    check("rd_addr_err", 128'(addr_err), 128'd0);
    tick();
    check("rd_late_valid", 128'(data_valid), 128'd0);
    check("rd_late_data", data_out, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/implode_read_sequencer.md
# implode_read_sequencer

Read-side controller between the implode datapath and the shared scratchpad read port. It streams the scratchpad twice in ascending address order, wrapping at NUM_ROUNDS<<3 entries. It hides fixed memory read latency behind a credit-limited prefetch FIFO and presents each word to implode with a data_valid/request_read handshake. It also flags address desynchronisation and supports abort/flush when the hash pipeline is restarted.

## Interface
- NUM_ROUNDS, 'h020, scratchpad size in units of 8 words; wrap point W = NUM_ROUNDS<<3
- RD_LATENCY, 3, cycles from accepted read to mem_rd_data valid (1..8)
- FIFO_DEPTH, 8, prefetch FIFO entries (power of two, 4..32)
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse, begin a two-pass stream at address 0
- abort  input  1  one-cycle pulse, cancel stream and flush
- request_read  input  1  implode ready to consume a word
- mem_address  input  32  address implode expects for the word it consumes
- data_out  output  128  FIFO head word (scratch_read to implode)
- data_valid  output  1  data_out is valid and consumed this cycle
- mem_rd_en  output  1  read request to scratchpad port
- mem_rd_addr  output  32  read address
- mem_grant  input  1  port accepts the read this cycle (shared port)
- mem_rd_data  input  128  read data, valid RD_LATENCY cycles after an accepted read
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse after the last word is consumed
- addr_err  output  1  sticky, a consumed word's address ≠ mem_address

## Operation
- States: IDLE, RUN, DRAIN, FLUSH.
- IDLE: start → RUN. Clear issue_addr, pop_addr, issue_cnt and pop_cnt to 0. Clear addr_err.
- RUN: mem_rd_en = 1 when credits > 0 and issue_cnt < 2W.
  - credits = FIFO_DEPTH − fifo_count − inflight.
  - An accepted read (mem_rd_en && mem_grant) increments issue_addr mod W and issue_cnt.
  - mem_rd_addr = issue_addr, held stable while mem_rd_en is high and mem_grant is low.
- RUN → DRAIN when issue_cnt reaches 2W.
- DRAIN: no issues. → IDLE on the pop of word 2W, with done pulsed the same cycle.
- Return path: a RD_LATENCY-deep valid shift register tracks accepted reads. A 1 at its output pushes mem_rd_data into the FIFO on that edge.
- Pop: data_valid = request_read && fifo_count ≠ 0, combinational. On a pop:
  - FIFO advances;
  - pop_addr increments mod W;
  - pop_cnt increments;
  - if mem_address ≠ pop_addr, addr_err sets and stays set until the next start.
- A push and a pop in the same cycle are legal at any occupancy, including full and empty. The FIFO never overflows because credits count in-flight reads.
- abort in RUN or DRAIN → FLUSH.
  - FLUSH: mem_rd_en = 0, data_valid = 0, FIFO cleared, returns discarded.
  - FLUSH exits to IDLE after exactly RD_LATENCY cycles, when inflight = 0.
  - abort in IDLE or FLUSH is ignored.
- start while not IDLE is ignored. Simultaneous start and abort in IDLE: start wins.
- Counters: issue_cnt and pop_cnt are $clog2(2W)+1 bits wide. Address counters are 32 bits and wrap W−1 → 0.

## Timing
- Reset values: data_out 0, data_valid 0, mem_rd_en 0, mem_rd_addr 0, busy 0, done 0, addr_err 0.
  - Reset also forces IDLE, empties the FIFO and clears the valid pipeline, including mid-stream.
- start sampled at edge 0 → busy = 1 and mem_rd_en = 1 in cycle 1 with address 0.
- With mem_grant = 1, the read accepted in cycle 1 returns in cycle 1+RD_LATENCY and is pushed at the end of that cycle.
  - First data_valid is possible in cycle 2+RD_LATENCY.
- Sustained throughput is 1 word/cycle when FIFO_DEPTH ≥ RD_LATENCY+1 and mem_grant and request_read stay high.
- data_out and the FIFO head are registered; there is no combinational path from mem_rd_data to data_out.
- done is high exactly in the cycle of the final pop; busy drops on the next cycle.

## Test plan
- Full stream, NUM_ROUNDS=2 (W=16), RD_LATENCY=3, memory word = address, grant and request_read always high.
  - Required: 32 pops with data 0..15, 0..15; first data_valid in cycle 5; done in cycle 36; addr_err = 0.
- Backpressure: request_read low for 20 cycles after cycle 4.
  - Required: mem_rd_en drops once fifo_count + inflight = 8; no word is lost or duplicated; the stream resumes in order.
- Grant stall: mem_grant low for cycles 3–6.
  - Required: mem_rd_addr holds 2 throughout; issue resumes at 2; the data sequence is unchanged.
- Abort at cycle 10 with 3 reads in flight.
  - Required: data_valid = 0 from cycle 11; FLUSH for 3 cycles; busy = 0 at cycle 14; a new start streams again from 0.
- Desync: implode presents mem_address = 5 when pop_addr = 4.
  - Required: addr_err = 1 the next cycle, sticky through done, cleared by the next start.
- Reset mid-DRAIN with the FIFO holding 4 words.
  - Required: all outputs return to reset values in the next cycle and no late return is pushed.
